// File: rtl/mgc_shift_r_pipe.sv
// Pipelined logical/arithmetic right shifter with valid/ready handshake, one stage per shift bit.
// Optional macro MGC_SHIFT_R_STICKY_EN adds a sticky output (OR of all bits shifted out).
module mgc_shift_r_pipe #(
    parameter int width_a = 8,
    parameter int signd_a = 1,
    parameter int width_s = 3,
    parameter int width_z = 8
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [width_a-1:0] a,
    input  logic [width_s-1:0] s,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [width_z-1:0] z,
    output logic               busy
`ifdef MGC_SHIFT_R_STICKY_EN
    ,
    output logic               sticky
`endif
);

    localparam int len  = (width_a > width_z) ? width_a : width_z;
    localparam int last = width_s - 1;
    localparam logic [len-1:0] hi_mask = {len{1'b1}} << width_a;

    logic [width_s-1:0] vld_r;
    logic [len-1:0]     data_r [width_s];
    logic [width_s-1:0] amt_r  [width_s];
    logic [width_s-1:0] fill_r;

    logic [width_s-1:0] rdy_s;
    logic               full_s;
    logic               fill_s;
    logic [len-1:0]     a_zx_s;
    logic [len-1:0]     ext_s;
    logic [width_s-1:0] src_vld_s;
    logic [len-1:0]     src_data_s [width_s];
    logic [width_s-1:0] src_amt_s  [width_s];
    logic [width_s-1:0] src_fill_s;

    // Shifting {fill, d} arithmetically replicates the fill bit, and saturates to all-fill for sh >= len.
    function automatic logic [len-1:0] shr_fill(input logic [len-1:0] d, input logic f, input int sh);
        logic signed [len:0] t;
        t = $signed({f, d});
        t = t >>> sh;
        return t[len-1:0];
    endfunction

`ifdef MGC_SHIFT_R_STICKY_EN
    logic [width_s-1:0] sticky_r;
    logic [width_s-1:0] src_sticky_s;

    function automatic logic lost_bits(input logic [len-1:0] d, input int sh);
        logic [len-1:0] keep;
        keep = {len{1'b1}} << sh;
        return |(d & ~keep);
    endfunction
`endif

    // Operand extension to len bits with the fill bit.
    always_comb begin
        a_zx_s = len'(a);
        if (signd_a != 0) begin
            fill_s = a[width_a-1];
        end else begin
            fill_s = 1'b0;
        end
        if (fill_s) begin
            ext_s = a_zx_s | hi_mask;
        end else begin
            ext_s = a_zx_s;
        end
    end

    // A stage can load when it is empty or every stage below it is able to move.
    always_comb begin
        rdy_s  = {width_s{1'b0}};
        full_s = 1'b0;
        for (int k = 0; k < width_s; k++) begin
            full_s = 1'b1;
            for (int j = k; j < width_s; j++) begin
                full_s = full_s & vld_r[j];
            end
            rdy_s[k] = out_rdy | ~full_s;
        end
    end

    // Source of each stage: the input port for stage 0, the previous register otherwise.
    always_comb begin
        src_vld_s     = {width_s{1'b0}};
        src_fill_s    = {width_s{1'b0}};
        src_vld_s[0]  = in_vld;
        src_data_s[0] = ext_s;
        src_amt_s[0]  = s;
        src_fill_s[0] = fill_s;
`ifdef MGC_SHIFT_R_STICKY_EN
        src_sticky_s    = {width_s{1'b0}};
        src_sticky_s[0] = 1'b0;
`endif
        for (int k = 1; k < width_s; k++) begin
            src_vld_s[k]  = vld_r[k-1];
            src_data_s[k] = data_r[k-1];
            src_amt_s[k]  = amt_r[k-1];
            src_fill_s[k] = fill_r[k-1];
`ifdef MGC_SHIFT_R_STICKY_EN
            src_sticky_s[k] = sticky_r[k-1];
`endif
        end
    end

    // Pipeline registers; data only loads with a valid token so stalled or drained outputs hold.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_r  <= {width_s{1'b0}};
            fill_r <= {width_s{1'b0}};
            for (int k = 0; k < width_s; k++) begin
                data_r[k] <= {len{1'b0}};
                amt_r[k]  <= {width_s{1'b0}};
            end
`ifdef MGC_SHIFT_R_STICKY_EN
            sticky_r <= {width_s{1'b0}};
`endif
        end else begin
            for (int k = 0; k < width_s; k++) begin
                if (rdy_s[k]) begin
                    vld_r[k] <= src_vld_s[k];
                    if (src_vld_s[k]) begin
                        amt_r[k]  <= src_amt_s[k];
                        fill_r[k] <= src_fill_s[k];
                        if (src_amt_s[k][k]) begin
                            data_r[k] <= shr_fill(src_data_s[k], src_fill_s[k], 1 << k);
                        end else begin
                            data_r[k] <= src_data_s[k];
                        end
`ifdef MGC_SHIFT_R_STICKY_EN
                        sticky_r[k] <= src_sticky_s[k] |
                                       (src_amt_s[k][k] & lost_bits(src_data_s[k], 1 << k));
`endif
                    end
                end
            end
        end
    end

    assign in_rdy  = rdy_s[0];
    assign out_vld = vld_r[last];
    assign z       = data_r[last][width_z-1:0];
    assign busy    = |vld_r;
`ifdef MGC_SHIFT_R_STICKY_EN
    assign sticky  = sticky_r[last];
`endif

endmodule

// File: tb/tb_mgc_shift_r_pipe.sv
// Scoreboard bench for mgc_shift_r_pipe: arithmetic 8/8, logical 8/8 and arithmetic 8->12 instances share one stimulus.
module tb_mgc_shift_r_pipe;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        in_vld;
    logic        out_rdy;
    logic [7:0]  a;
    logic [2:0]  s;

    logic        in_rdy_s, out_vld_s, busy_s;
    logic [7:0]  z_s;
    logic        in_rdy_u, out_vld_u, busy_u;
    logic [7:0]  z_u;
    logic        in_rdy_w, out_vld_w, busy_w;
    logic [11:0] z_w;
`ifdef MGC_SHIFT_R_STICKY_EN
    logic        st_s, st_u, st_w;
`endif

    typedef struct {
        logic [7:0]  zs;
        logic [7:0]  zu;
        logic [11:0] zw;
        logic        st;
        int          pc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_mode = 1'b0;

    always #5 clk = ~clk;

    mgc_shift_r_pipe #(.width_a(8), .signd_a(1), .width_s(3), .width_z(8)) u_s (
        .clk(clk), .arst_n(arst_n), .in_vld(in_vld), .in_rdy(in_rdy_s), .a(a), .s(s),
        .out_vld(out_vld_s), .out_rdy(out_rdy), .z(z_s), .busy(busy_s)
`ifdef MGC_SHIFT_R_STICKY_EN
        , .sticky(st_s)
`endif
    );

    mgc_shift_r_pipe #(.width_a(8), .signd_a(0), .width_s(3), .width_z(8)) u_u (
        .clk(clk), .arst_n(arst_n), .in_vld(in_vld), .in_rdy(in_rdy_u), .a(a), .s(s),
        .out_vld(out_vld_u), .out_rdy(out_rdy), .z(z_u), .busy(busy_u)
`ifdef MGC_SHIFT_R_STICKY_EN
        , .sticky(st_u)
`endif
    );

    mgc_shift_r_pipe #(.width_a(8), .signd_a(1), .width_s(3), .width_z(12)) u_w (
        .clk(clk), .arst_n(arst_n), .in_vld(in_vld), .in_rdy(in_rdy_w), .a(a), .s(s),
        .out_vld(out_vld_w), .out_rdy(out_rdy), .z(z_w), .busy(busy_w)
`ifdef MGC_SHIFT_R_STICKY_EN
        , .sticky(st_w)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic [7:0] av, input int sv, input bit sg);
        int v;
        if (sg) v = int'($signed(av));
        else    v = int'(av);
        v = v >>> sv;
        return v[11:0];
    endfunction

    // One clock: score the output transfer, record the input transfer, then step past the edge.
    task automatic tick(output bit acc);
        exp_t        e;
        logic [11:0] ms;
        @(negedge clk);
        acc = in_vld && in_rdy_s;
        chk("vld_agree", {30'd0, out_vld_u, out_vld_w}, {30'd0, out_vld_s, out_vld_s});
        chk("rdy_agree", {30'd0, in_rdy_u, in_rdy_w}, {30'd0, in_rdy_s, in_rdy_s});
        if (out_vld_s && out_rdy) begin
            chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("z_arith", {24'd0, z_s}, {24'd0, e.zs});
                chk("z_logic", {24'd0, z_u}, {24'd0, e.zu});
                chk("z_wide", {20'd0, z_w}, {20'd0, e.zw});
                if (e.lat) chk("latency", cyc - e.pc, 32'd3);
`ifdef MGC_SHIFT_R_STICKY_EN
                chk("sticky_logic", {31'd0, st_u}, {31'd0, e.st});
                chk("sticky_arith", {31'd0, st_s}, {31'd0, e.st});
`endif
            end
        end
        if (acc) begin
            ms    = model(a, int'(s), 1'b1);
            e.zs  = ms[7:0];
            e.zw  = ms;
            ms    = model(a, int'(s), 1'b0);
            e.zu  = ms[7:0];
            e.st  = (a & ((8'd1 << s) - 8'd1)) != 8'd0;
            e.pc  = cyc;
            e.lat = lat_mode;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] av, input logic [2:0] sv);
        bit acc;
        a = av; s = sv; in_vld = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) tick(acc);
        chk("send_accepted", {31'd0, acc}, 32'd1);
        in_vld = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        out_rdy = 1'b1;
        in_vld  = 1'b0;
        for (int i = 0; i < 12 && sb.size() > 0; i++) tick(acc);
        tick(acc);
        chk("drained", sb.size(), 32'd0);
        chk("busy_idle", {31'd0, busy_s}, 32'd0);
    endtask

    initial begin
        bit          acc;
        logic [7:0]  held;
        logic [11:0] held_w;
        arst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b1; a = 8'h00; s = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld", {31'd0, out_vld_s}, 32'd0);
        chk("rst_z", {24'd0, z_s}, 32'd0);
        chk("rst_busy", {31'd0, busy_s}, 32'd0);
        chk("rst_in_rdy", {31'd0, in_rdy_s}, 32'd1);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single operands with latency check
        lat_mode = 1'b1;
        send(8'h90, 3'd3); drain();
        send(8'h80, 3'd7); drain();
        send(8'h90, 3'd0); drain();
        send(8'h90, 3'd4); drain();
        send(8'h90, 3'd5); drain();
        send(8'h91, 3'd3); drain();

        // Back-to-back, full throughput
        for (int i = 0; i < 8; i++) begin
            a = 8'h7F; s = 3'(i); in_vld = 1'b1;
            tick(acc);
            chk("b2b_accept", {31'd0, acc}, 32'd1);
            chk("b2b_in_rdy", {31'd0, in_rdy_s}, 32'd1);
        end
        in_vld = 1'b0;
        drain();

        // Backpressure: three fill the pipe, fourth waits
        lat_mode = 1'b0;
        out_rdy  = 1'b0;
        a = 8'h90; s = 3'd1; in_vld = 1'b1; tick(acc);
        chk("bp_acc0", {31'd0, acc}, 32'd1);
        a = 8'h91; s = 3'd2; tick(acc);
        chk("bp_acc1", {31'd0, acc}, 32'd1);
        a = 8'hA5; s = 3'd5; tick(acc);
        chk("bp_acc2", {31'd0, acc}, 32'd1);
        a = 8'h3C; s = 3'd6;
        chk("bp_in_rdy_low", {31'd0, in_rdy_s}, 32'd0);
        held   = z_s;
        held_w = z_w;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            chk("bp_no_accept", {31'd0, acc}, 32'd0);
            chk("bp_out_vld", {31'd0, out_vld_s}, 32'd1);
            chk("bp_z_stable", {24'd0, z_s}, {24'd0, held});
            chk("bp_zw_stable", {20'd0, z_w}, {20'd0, held_w});
        end
        out_rdy = 1'b1;
        tick(acc);
        chk("bp_acc3_first_cycle", {31'd0, acc}, 32'd1);
        in_vld = 1'b0;
        drain();

        // Reset with two operands in flight
        a = 8'h55; s = 3'd1; in_vld = 1'b1; tick(acc);
        a = 8'hC3; s = 3'd2; tick(acc);
        in_vld = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        chk("mid_rst_out_vld", {31'd0, out_vld_s}, 32'd0);
        chk("mid_rst_z", {24'd0, z_s}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_s}, 32'd0);
        chk("mid_rst_in_rdy", {31'd0, in_rdy_s}, 32'd1);
        sb.delete();
        @(posedge clk);
        #3;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            chk("no_stale", {31'd0, out_vld_s}, 32'd0);
        end
        lat_mode = 1'b1;
        send(8'hE7, 3'd2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mgc_shift_r_pipe.md
Name: mgc_shift_r_pipe

Overview:
- Pipelined right shifter, logical or arithmetic; the right-shift counterpart of the combinational left-shift library component.
- Intended for Catapult-generated datapaths where a wide barrel shift must be retimed across cycles.
- Logarithmic structure: one register stage per shift-amount bit.
- valid/ready handshake on input and output; full throughput with backpressure.

Parameters:
- width_a, 8: operand width.
- signd_a, 1: 1 = arithmetic (sign fill from a[width_a-1]); 0 = logical (zero fill).
- width_s, 3: shift-amount width; also the number of pipeline stages.
- width_z, 8: result width.

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  asynchronous reset, active-low.
- in_vld  in  1  input operand valid.
- in_rdy  out  1  block can accept an operand this cycle.
- a  in  width_a  operand.
- s  in  width_s  unsigned shift amount.
- out_vld  out  1  z valid.
- out_rdy  in  1  consumer accepts z.
- z  out  width_z  result.
- busy  out  1  any stage holds valid data.

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset arst_n.
- Width rules:
  - len = max(width_a, width_z).
  - a is extended to len bits: sign fill if signd_a, else zero fill.
  - Result is the extended value >> s, filled with the same fill bit; z = low width_z bits of the result.
  - s >= len gives all fill bits: 0 for logical, replicated sign for arithmetic.
- Pipeline stages k = 0..width_s-1:
  - Stage k registers data shifted right by 2^k if the captured s[k] = 1, else unshifted.
  - Each stage carries valid, data (len bits), the remaining s bits, and the fill bit.
  - If 2^k >= len and s[k] = 1, stage k output is all fill.
- Handshake:
  - Stage k advances when rdy[k] = ~vld[k] | rdy[k+1], where rdy[width_s] = out_rdy.
  - in_rdy = rdy[0]. Input transfer occurs when in_vld & in_rdy.
  - Output transfer occurs when out_vld & out_rdy. out_vld = vld of the last stage; z = that stage's low width_z bits.
- Latency and throughput:
  - width_s cycles from input transfer to out_vld, with no stall.
  - One result per cycle in steady state.
  - Bubbles collapse: an empty stage accepts even while a downstream stage is stalled.
- Stall: while out_vld=1 and out_rdy=0, z and out_vld hold stable. After width_s operands are accepted, in_rdy=0.
- Simultaneous events: if the last stage transfers out while the upstream stage has data, the new data moves in the same cycle with no bubble.
- Reset:
  - arst_n low clears all valid bits and zeroes data registers, immediately and asynchronously.
  - Outputs during and after reset: out_vld=0, z=0, busy=0, in_rdy=1.
  - Reset mid-operation drops all in-flight operands; none appear after release.
- Ordering is strictly FIFO. No data manipulation occurs beyond the shift.
- busy = OR of all stage valid bits.

Optional Feature:
- Macro: MGC_SHIFT_R_STICKY_EN.
- Defined:
  - Extra output port sticky (1 bit, out), valid with out_vld and stable under stall like z.
  - sticky = OR of all bits shifted out below bit 0 of the len-bit extended operand.
  - For s >= len, sticky = OR of the whole extended operand.
  - A per-stage sticky register is ORed stage to stage; it resets to 0.
  - Intended for rounding logic downstream.
- Undefined: the port and its registers are absent; all other behaviour is identical.

Test Plan:
- Default params (8/1/3/8), a=0x90, s=3, out_rdy=1 → out_vld high exactly 3 cycles after transfer, z=0xF2. Same with signd_a=0 → z=0x12.
- signd_a=1, a=0x80, s=7 → z=0xFF; signd_a=0, a=0x80, s=7 → z=0x01. width_a=8, width_z=12, signd_a=1, a=0x90, s=0 → z=0xF90.
- Back-to-back, out_rdy=1: s=0..7 on a=0x7F, one per cycle → z=0x7F,0x3F,0x1F,0x0F,0x07,0x03,0x01,0x00 on consecutive cycles; in_rdy never drops.
- Backpressure, out_rdy=0:
  - Offer 4 operands → in_rdy=0 after 3 accepted; z stable for 5 stall cycles.
  - Raise out_rdy → all results in order, 4th accepted on the first cycle out_rdy=1.
- Reset mid-operation: arst_n pulses low with 2 operands in flight → out_vld=0, z=0, busy=0 immediately; no stale result after release; next operand returns after 3 cycles.
- MGC_SHIFT_R_STICKY_EN, logical: a=0x90, s=4 → z=0x09, sticky=0; a=0x90, s=5 → z=0x04, sticky=1; a=0x91, s=3 → z=0x12, sticky=1.
